// File: rtl/mio_rx.sv
// mio_rx: inbound half of the MIO block.
//   - 8N1-style UART receiver (5..8 data bits) feeding a small RX FIFO
//   - 4-bit GPIO input synchroniser
//   - single-beat IOB read service on two ports (0 = GPIO, 1 = UART)
//   - level interrupt while received bytes are pending
// Ports:
//   clk               core clock
//   rst               asynchronous active-high reset (release expected synchronous to clk)
//   uart_rxd          serial input, idle high, asynchronous to clk
//   gpio_in[3:0]      GPIO inputs, asynchronous to clk
//   iob__mio_rd_val   read request pulse
//   iob__mio_rd_port  0 = GPIO, 1 = UART
//   mio__iob_rd_done  read complete pulse, one cycle after the request
//   mio__iob_rdata    read data, zero outside the done cycle
//   uart_rx_irq       high while the RX FIFO holds at least one byte
module mio_rx #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned BIT_RATE     = 115200,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    input  logic [3:0]  gpio_in,
    input  logic        iob__mio_rd_val,
    input  logic        iob__mio_rd_port,
    output logic        mio__iob_rd_done,
    output logic [31:0] mio__iob_rdata,
    output logic        uart_rx_irq
);

    localparam int unsigned CPB   = CLK_HZ / BIT_RATE;
    localparam int unsigned HALF  = CPB / 32'd2;
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 32'd1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       IDX_LAST  = 3'(PAYLOAD_BITS - 32'd1);
    localparam logic [PTR_W:0]   PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Synchronisers; rxd_prev_r is one more stage used for falling-edge detection
    logic                    rxd_meta_r, rxd_sync_r, rxd_prev_r;
    logic [3:0]              gpio_meta_r, gpio_sync_r;

    rx_state_e               state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [2:0]              idx_r, idx_s;
    logic [PAYLOAD_BITS-1:0] shreg_r, shreg_s;
    logic                    push_s, frm_set_s;

    logic [PAYLOAD_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic                    empty_s, full_s, rd_uart_s, pop_s, wr_en_s, ovf_set_s;
    logic                    frm_err_r, ovf_r, frm_err_s, ovf_s;
    logic [PAYLOAD_BITS-1:0] head_s;
    logic [7:0]              head8_s;
    logic [31:0]             rdata_s;
    logic                    rd_done_r, irq_r;
    logic [31:0]             rdata_r;

    // Two-flop synchronisers for the asynchronous inputs plus the rxd history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_r  <= 1'b1;
            rxd_sync_r  <= 1'b1;
            rxd_prev_r  <= 1'b1;
            gpio_meta_r <= 4'h0;
            gpio_sync_r <= 4'h0;
        end else begin
            rxd_meta_r  <= uart_rxd;
            rxd_sync_r  <= rxd_meta_r;
            rxd_prev_r  <= rxd_sync_r;
            gpio_meta_r <= gpio_in;
            gpio_sync_r <= gpio_meta_r;
        end
    end

    // RX FSM state, baud counter, bit index and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shreg_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
        end
    end

    // RX FSM next state: samples land mid-bit, half a bit after the start edge then every bit
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shreg_s   = shreg_r;
        push_s    = 1'b0;
        frm_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Only a high-to-low transition starts a frame, so a stuck-low line is ignored
                if (rxd_prev_r && !rxd_sync_r) begin
                    state_s = ST_START;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    if (!rxd_sync_r) begin
                        state_s = ST_DATA;
                        cnt_s   = '0;
                        idx_s   = 3'd0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    shreg_s[idx_r] = rxd_sync_r;
                    cnt_s          = '0;
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    if (rxd_sync_r) begin
                        push_s = 1'b1;
                    end else begin
                        frm_set_s = 1'b1;
                    end
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // FIFO control: a full FIFO only accepts a new byte when the head pops in the same cycle
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
        rd_uart_s = iob__mio_rd_val && iob__mio_rd_port;
        pop_s     = rd_uart_s && !empty_s;
        wr_en_s   = push_s && (!full_s || pop_s);
        ovf_set_s = push_s && full_s && !pop_s;
        if (wr_en_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        // A set in the same cycle as a clearing read wins
        if (frm_set_s) begin
            frm_err_s = 1'b1;
        end else if (rd_uart_s) begin
            frm_err_s = 1'b0;
        end else begin
            frm_err_s = frm_err_r;
        end
        if (ovf_set_s) begin
            ovf_s = 1'b1;
        end else if (rd_uart_s) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // Read data mux: flags and head reflect the state before this cycle's push/pop
    always_comb begin
        head8_s = 8'h00;
        if (empty_s) begin
            head_s = '0;
        end else begin
            head_s = mem_r[rd_ptr_r[PTR_W-1:0]];
        end
        head8_s[PAYLOAD_BITS-1:0] = head_s;
        if (iob__mio_rd_val) begin
            if (iob__mio_rd_port) begin
                rdata_s = {21'd0, ovf_r, frm_err_r, !empty_s, head8_s};
            end else begin
                rdata_s = {28'd0, gpio_sync_r};
            end
        end else begin
            rdata_s = 32'd0;
        end
    end

    // FIFO storage, pointers and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            frm_err_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= shreg_r;
            end
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            frm_err_r <= frm_err_s;
            ovf_r     <= ovf_s;
        end
    end

    // Registered read response and interrupt (irq tracks the updated FIFO occupancy)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_done_r <= 1'b0;
            rdata_r   <= 32'd0;
            irq_r     <= 1'b0;
        end else begin
            rd_done_r <= iob__mio_rd_val;
            rdata_r   <= rdata_s;
            irq_r     <= (wr_ptr_s != rd_ptr_s);
        end
    end

    assign mio__iob_rd_done = rd_done_r;
    assign mio__iob_rdata   = rdata_r;
    assign uart_rx_irq      = irq_r;

endmodule

// File: tb/tb_mio_rx.sv
// Self-checking bench for mio_rx (10 clocks per bit, 8 data bits, 4-entry FIFO).
module tb_mio_rx;

    localparam int CPB   = 10;
    localparam int HALF  = 5;
    localparam int PB    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic [3:0]  gpio_in = 4'h0;
    logic        rd_val = 1'b0;
    logic        rd_port = 1'b0;
    logic        rd_done;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    mio_rx #(
        .CLK_HZ(1000000),
        .BIT_RATE(100000),
        .PAYLOAD_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rxd(uart_rxd),
        .gpio_in(gpio_in),
        .iob__mio_rd_val(rd_val),
        .iob__mio_rd_port(rd_port),
        .mio__iob_rd_done(rd_done),
        .mio__iob_rdata(rdata),
        .uart_rx_irq(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Line history per clock edge; the receiver only ever sees the line two edges late.
    logic       raw_h  [0:65535];
    logic [3:0] gpio_h [0:65535];
    int         cyc = 0;
    bit         busy = 1'b0;
    int         e_t = 0;
    logic [7:0] q[$];
    bit         m_frm = 1'b0, m_ovf = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    bit         exp_done = 1'b0, exp_irq = 1'b0;

    function automatic int ix(input int t);
        return t & 32'h0000FFFF;
    endfunction

    initial begin
        logic [7:0] rx_byte;
        bit         do_push, do_frm;
        for (int i = 0; i < 65536; i++) begin
            raw_h[i]  = 1'b1;
            gpio_h[i] = 4'h0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                raw_h[ix(cyc)]  = 1'b1;
                gpio_h[ix(cyc)] = 4'h0;
                busy = 1'b0;
                q.delete();
                m_frm = 1'b0;
                m_ovf = 1'b0;
                exp_done = 1'b0;
                exp_rdata = 32'd0;
                exp_irq = 1'b0;
            end else begin
                raw_h[ix(cyc)]  = uart_rxd;
                gpio_h[ix(cyc)] = gpio_in;
                do_push = 1'b0;
                do_frm  = 1'b0;
                rx_byte = 8'h00;
                // Frame timing measured from the edge at which the start is seen
                if (busy) begin
                    if (cyc == e_t + HALF) begin
                        if (raw_h[ix(cyc - 2)]) busy = 1'b0;
                    end else if (cyc == e_t + HALF + (PB + 1) * CPB) begin
                        for (int i = 0; i < PB; i++)
                            rx_byte[i] = raw_h[ix(e_t + HALF + (i + 1) * CPB - 2)];
                        if (raw_h[ix(cyc - 2)]) do_push = 1'b1;
                        else do_frm = 1'b1;
                        busy = 1'b0;
                    end
                end else if (raw_h[ix(cyc - 3)] && !raw_h[ix(cyc - 2)]) begin
                    busy = 1'b1;
                    e_t  = cyc;
                end
                exp_done  = rd_val;
                exp_rdata = 32'd0;
                if (rd_val) begin
                    if (rd_port) begin
                        if (q.size() != 0) begin
                            exp_rdata = {21'd0, m_ovf, m_frm, 1'b1, q[0]};
                            void'(q.pop_front());
                        end else begin
                            exp_rdata = {21'd0, m_ovf, m_frm, 1'b0, 8'h00};
                        end
                        m_frm = 1'b0;
                        m_ovf = 1'b0;
                    end else begin
                        exp_rdata = {28'd0, gpio_h[ix(cyc - 2)]};
                    end
                end
                if (do_push) begin
                    if (q.size() < DEPTH) q.push_back(rx_byte);
                    else m_ovf = 1'b1;
                end
                if (do_frm) m_frm = 1'b1;
                exp_irq = (q.size() != 0);
            end
            check("rd_done", {31'd0, rd_done}, {31'd0, exp_done});
            check("rdata", rdata, exp_rdata);
            check("irq", {31'd0, irq}, {31'd0, exp_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < PB; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic read_chk(input bit p, input logic [31:0] lit, input string name);
        @(negedge clk);
        rd_port = p;
        rd_val  = 1'b1;
        @(posedge clk);
        #2;
        check(name, rdata, lit);
        check({name, "_model"}, exp_rdata, lit);
        check({name, "_done"}, {31'd0, rd_done}, 32'd1);
        @(negedge clk);
        rd_val = 1'b0;
    endtask

    task automatic pulse_rd(input bit p);
        rd_port = p;
        rd_val  = 1'b1;
        @(negedge clk);
        rd_val = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    bit tx_done = 1'b0;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_done", {31'd0, rd_done}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_irq_up", {31'd0, irq}, 32'd1);
        read_chk(1'b1, 32'h000001A5, "a5_read");
        check("a5_irq_down", {31'd0, irq}, 32'd0);
        read_chk(1'b1, 32'h00000000, "a5_empty");

        // Overflow: fifth byte dropped
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        repeat (4) @(negedge clk);
        read_chk(1'b1, 32'h00000501, "ovf_r1");
        read_chk(1'b1, 32'h00000102, "ovf_r2");
        read_chk(1'b1, 32'h00000103, "ovf_r3");
        read_chk(1'b1, 32'h00000104, "ovf_r4");
        read_chk(1'b1, 32'h00000000, "ovf_r5");

        // Framing error
        send_frame(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        check("frm_irq", {31'd0, irq}, 32'd0);
        read_chk(1'b1, 32'h00000200, "frm_r1");
        read_chk(1'b1, 32'h00000000, "frm_r2");

        // Short low glitch on idle line
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_irq", {31'd0, irq}, 32'd0);
        read_chk(1'b1, 32'h00000000, "glitch_read");

        // GPIO
        gpio_in = 4'hB;
        repeat (2) @(negedge clk);
        read_chk(1'b0, 32'h0000000B, "gpio_read");

        // Reset in the middle of a frame with two bytes queued
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = (i % 2 == 0);
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        send_frame(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        read_chk(1'b1, 32'h0000017E, "post_rst_7e");
        read_chk(1'b1, 32'h00000000, "post_rst_empty");

        // Random traffic checked cycle by cycle against the model
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        uart_rxd = 1'b0;
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                        uart_rxd = 1'b1;
                        repeat ($urandom_range(2, 10)) @(negedge clk);
                    end
                    send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
                    repeat ($urandom_range(2, 25)) @(negedge clk);
                end
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    repeat ($urandom_range(1, 60)) @(negedge clk);
                    if ($urandom_range(0, 3) == 0) gpio_in = 4'($urandom_range(0, 15));
                    pulse_rd($urandom_range(0, 3) != 0);
                end
            end
        join

        repeat (150) @(negedge clk);
        for (int i = 0; i < 6; i++) pulse_rd(1'b1);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
